// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and latency definitions for the ALU issue/sequencing stage.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_LSH = 3'd2;
    localparam logic [2:0] OP_RSH = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int ARITH_LAT_DEF = 2;
    localparam int SHIFT_LAT_DEF = 4;

    // Shifts run through the longer shifter path and use SHIFT_LAT.
    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_LSH) || (op == OP_RSH);
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational op-to-strobe decoder; all strobes stay low unless enabled.
module alu_op_decoder
    import alu_seq_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic       en_i,
    output logic       add_o,
    output logic       sub_o,
    output logic       lsh_o,
    output logic       rsh_o,
    output logic       and_o,
    output logic       or_o,
    output logic       xor_o
);

    always_comb begin
        add_o = 1'b0;
        sub_o = 1'b0;
        lsh_o = 1'b0;
        rsh_o = 1'b0;
        and_o = 1'b0;
        or_o  = 1'b0;
        xor_o = 1'b0;
        if (en_i) begin
            case (op_i)
                OP_ADD:  add_o = 1'b1;
                OP_SUB:  sub_o = 1'b1;
                OP_LSH:  lsh_o = 1'b1;
                OP_RSH:  rsh_o = 1'b1;
                OP_AND:  and_o = 1'b1;
                OP_OR:   or_o  = 1'b1;
                OP_XOR:  xor_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issue stage ahead of the ALU: accepts one instruction, holds strobes/operands for the
// ALU latency, captures the result into the accumulator and hands it downstream.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ARITH_LAT = ARITH_LAT_DEF,
    parameter int SHIFT_LAT = SHIFT_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] instr_op,
    input  logic [3:0] instr_a,
    input  logic [3:0] instr_b,
    input  logic       use_acc,
    output logic       alu_add,
    output logic       alu_sub,
    output logic       alu_lsh,
    output logic       alu_rsh,
    output logic       alu_and,
    output logic       alu_or,
    output logic       alu_xor,
    output logic [3:0] alu_in1,
    output logic [3:0] alu_in2,
    input  logic [3:0] alu_out,
    input  logic       alu_overflow,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_overflow,
    output logic [3:0] acc,
    output logic [1:0] dbg_state
);

    localparam logic [3:0] ARITH_CNT = 4'(ARITH_LAT - 1);
    localparam logic [3:0] SHIFT_CNT = 4'(SHIFT_LAT - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // instr_ready/res_valid depend on registered state only; upstream and downstream
    // must hold their side stable until the transfer edge.

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] res_data_q, res_data_d;
    logic       res_ovf_q, res_ovf_d;
    logic [3:0] acc_q, acc_d;
    logic       exec_en;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_ovf_d  = res_ovf_q;
        acc_d      = acc_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    op_d = instr_op;
                    a_d  = use_acc ? acc_q : instr_a;
                    b_d  = instr_b;
                    if (instr_op == OP_CLR) begin
                        res_data_d = 4'd0;
                        res_ovf_d  = 1'b0;
                        acc_d      = 4'd0;
                        state_d    = RESP;
                    end else begin
                        cnt_d   = is_shift(instr_op) ? SHIFT_CNT : ARITH_CNT;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                // The ALU output is valid on the edge the counter reaches zero.
                if (cnt_q == 4'd0) begin
                    res_data_d = alu_out;
                    res_ovf_d  = alu_overflow;
                    acc_d      = alu_out;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= 3'd0;
            a_q        <= 4'd0;
            b_q        <= 4'd0;
            cnt_q      <= 4'd0;
            res_data_q <= 4'd0;
            res_ovf_q  <= 1'b0;
            acc_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_ovf_q  <= res_ovf_d;
            acc_q      <= acc_d;
        end
    end

    assign exec_en = (state_q == EXEC);

    alu_op_decoder u_dec (
        .op_i  (op_q),
        .en_i  (exec_en),
        .add_o (alu_add),
        .sub_o (alu_sub),
        .lsh_o (alu_lsh),
        .rsh_o (alu_rsh),
        .and_o (alu_and),
        .or_o  (alu_or),
        .xor_o (alu_xor)
    );

    assign alu_in1      = exec_en ? a_q : 4'd0;
    assign alu_in2      = exec_en ? b_q : 4'd0;
    assign instr_ready  = (state_q == IDLE);
    assign res_valid    = (state_q == RESP);
    assign res_data     = res_data_q;
    assign res_overflow = res_ovf_q;
    assign acc          = acc_q;
    assign dbg_state    = state_q;

endmodule
